// File: rtl/sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_pkg
//  Description : Shared state encoding for the per-channel debounce FSM.
//                Bit 1 of every state equals the debounced level it drives.
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_LO   = 2'b00;
    localparam state_t PEND_HI = 2'b01;
    localparam state_t ST_HI   = 2'b11;
    localparam state_t PEND_LO = 2'b10;

endpackage
`default_nettype wire

// File: rtl/sync_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_debounce_if
//  Description : Data bundle between the synchronizer-side producer and the
//                debouncer: synchronized input plus level/edge outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sync_debounce_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    // Producer side: drives the synchronized bus, observes the clean outputs.
    modport master (output din, input dout, input rise, input fall);
    // Debouncer side.
    modport slave  (input din, output dout, output rise, output fall);
endinterface
`default_nettype wire

// File: rtl/sync_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_ch
//  Description : One debounce channel: 4-state FSM with a run-length counter,
//                registered level and single-cycle rise/fall pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_ch
    import sync_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic din,
    output logic      dout,
    output logic      rise,
    output logic      fall
);

    localparam int            CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam bit            C_SINGLE = (DEBOUNCE_CYC == 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Next-state logic: a new level is accepted only after DEBOUNCE_CYC equal
    // samples; any disagreeing sample aborts back to the settled state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LO: begin
                cnt_d = '0;
                if (din) begin
                    if (C_SINGLE) begin
                        state_d = ST_HI;
                        dout_d  = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = PEND_HI;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            PEND_HI: begin
                if (din) begin
                    if (cnt_q == C_LAST) begin
                        state_d = ST_HI;
                        dout_d  = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end
            end
            ST_HI: begin
                cnt_d = '0;
                if (!din) begin
                    if (C_SINGLE) begin
                        state_d = ST_LO;
                        dout_d  = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = PEND_LO;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            PEND_LO: begin
                if (!din) begin
                    if (cnt_q == C_LAST) begin
                        state_d = ST_LO;
                        dout_d  = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
                dout_d  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset matches the synchronizer's
    // reset value of 0 so no edge is reported on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sync_debounce
//  Description : WIDTH independent debounce channels behind the synchronizer,
//                presenting clean levels plus rise/fall pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_debounce
    import sync_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int DEBOUNCE_CYC = 16
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    sync_debounce_if.slave bus
);

    logic [WIDTH-1:0] w_dout;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    // One fully independent channel per bit.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            debounce_ch #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_ch (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (bus.din[i]),
                .dout  (w_dout[i]),
                .rise  (w_rise[i]),
                .fall  (w_fall[i])
            );
        end
    endgenerate

    assign bus.dout = w_dout;
    assign bus.rise = w_rise;
    assign bus.fall = w_fall;

endmodule
`default_nettype wire

// File: tb/tb_sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_debounce
//  Description : Scoreboard bench for sync_debounce with three configurations
//                (DEBOUNCE_CYC 4/WIDTH 2, DEBOUNCE_CYC 1, DEBOUNCE_CYC 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_debounce;

    logic clk = 1'b0;
    logic rst4, rst1, rst8;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sync_debounce_if #(.WIDTH(2)) ifc4 ();
    sync_debounce_if #(.WIDTH(1)) ifc1 ();
    sync_debounce_if #(.WIDTH(1)) ifc8 ();

    sync_debounce #(.WIDTH(2), .DEBOUNCE_CYC(4)) dut4 (.clk(clk), .rst_n(rst4), .bus(ifc4.slave));
    sync_debounce #(.WIDTH(1), .DEBOUNCE_CYC(1)) dut1 (.clk(clk), .rst_n(rst1), .bus(ifc1.slave));
    sync_debounce #(.WIDTH(1), .DEBOUNCE_CYC(8)) dut8 (.clk(clk), .rst_n(rst8), .bus(ifc8.slave));

    typedef struct {
        int         id;
        logic [1:0] dout;
        logic [1:0] rise;
        logic [1:0] fall;
        string      name;
    } exp_t;

    exp_t q[$];

    // Expected outputs after the next rising edge.
    task automatic push(input int id, input logic [1:0] d, input logic [1:0] r,
                        input logic [1:0] f, input string nm);
        exp_t e;
        e.id = id; e.dout = d; e.rise = r; e.fall = f; e.name = nm;
        q.push_back(e);
    endtask

    // Move to the drive point: just after the falling edge, once the monitor
    // has consumed the previous cycle's expectations.
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Monitor: outputs are presented every cycle, compared at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t       e;
                logic [1:0] ad, ar, af;
                e = q.pop_front();
                case (e.id)
                    0:       begin ad = ifc4.dout;         ar = ifc4.rise;         af = ifc4.fall;         end
                    1:       begin ad = {1'b0, ifc1.dout}; ar = {1'b0, ifc1.rise}; af = {1'b0, ifc1.fall}; end
                    default: begin ad = {1'b0, ifc8.dout}; ar = {1'b0, ifc8.rise}; af = {1'b0, ifc8.fall}; end
                endcase
                checks++;
                if (ad !== e.dout || ar !== e.rise || af !== e.fall) begin
                    failures++;
                    $display("FAIL %s t=%0t id=%0d dout=%b/%b rise=%b/%b fall=%b/%b (actual/required)",
                             e.name, $time, e.id, ad, e.dout, ar, e.rise, af, e.fall);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        bit pat_b[8] = '{1, 0, 1, 1, 1, 1, 1, 1};
        bit pat_1[5] = '{1, 0, 1, 0, 0};
        logic [1:0] ed, er;

        rst4 = 1'b0; rst1 = 1'b0; rst8 = 1'b0;
        ifc4.din = '0; ifc1.din = '0; ifc8.din = '0;

        // Reset state of all three configurations.
        tick();
        push(0, 2'b00, 2'b00, 2'b00, "rst_state4");
        push(1, 2'b00, 2'b00, 2'b00, "rst_state1");
        push(2, 2'b00, 2'b00, 2'b00, "rst_state8");
        tick();
        rst4 = 1'b1; rst1 = 1'b1; rst8 = 1'b1;
        push(0, 2'b00, 2'b00, 2'b00, "idle4");
        push(1, 2'b00, 2'b00, 2'b00, "idle1");
        push(2, 2'b00, 2'b00, 2'b00, "idle8");

        // DC=4: reset held with din=1 keeps outputs low.
        for (int k = 0; k < 3; k++) begin
            tick(); rst4 = 1'b0; ifc4.din = 2'b01;
            push(0, 2'b00, 2'b00, 2'b00, "rst_hold_din1");
        end
        // Release: rise on the 4th edge (k=3).
        for (int k = 0; k < 6; k++) begin
            tick(); rst4 = 1'b1; ifc4.din = 2'b01;
            push(0, (k >= 3) ? 2'b01 : 2'b00, (k == 3) ? 2'b01 : 2'b00, 2'b00, "rst_release_rise");
        end
        // Falling side: fall on k=3.
        for (int k = 0; k < 6; k++) begin
            tick(); ifc4.din = 2'b00;
            push(0, (k < 3) ? 2'b01 : 2'b00, 2'b00, (k == 3) ? 2'b01 : 2'b00, "fall_edge");
        end

        // Glitch of 3 samples is rejected.
        for (int k = 0; k < 6; k++) begin
            tick(); ifc4.din = (k < 3) ? 2'b01 : 2'b00;
            push(0, 2'b00, 2'b00, 2'b00, "glitch_reject");
        end
        // Clean edge held 10 cycles: rise at k=3, no fall.
        for (int k = 0; k < 10; k++) begin
            tick(); ifc4.din = 2'b01;
            push(0, (k >= 3) ? 2'b01 : 2'b00, (k == 3) ? 2'b01 : 2'b00, 2'b00, "clean_rise");
        end
        // Glitch low of 3 samples while high is rejected, then a real fall.
        for (int k = 0; k < 3; k++) begin
            tick(); ifc4.din = 2'b00;
            push(0, 2'b01, 2'b00, 2'b00, "glitch_lo_reject");
        end
        for (int k = 0; k < 6; k++) begin
            tick(); ifc4.din = 2'b01;
            push(0, 2'b01, 2'b00, 2'b00, "hold_high");
        end
        for (int k = 0; k < 6; k++) begin
            tick(); ifc4.din = 2'b00;
            push(0, (k < 3) ? 2'b01 : 2'b00, 2'b00, (k == 3) ? 2'b01 : 2'b00, "clean_fall");
        end

        // Bounce on bit0 with bit1 constant 1 from reset.
        for (int k = 0; k < 2; k++) begin
            tick(); rst4 = 1'b0; ifc4.din = 2'b10;
            push(0, 2'b00, 2'b00, 2'b00, "bounce_rst");
        end
        for (int k = 0; k < 8; k++) begin
            tick(); rst4 = 1'b1; ifc4.din = {1'b1, pat_b[k]};
            ed = {(k >= 3) ? 1'b1 : 1'b0, (k >= 5) ? 1'b1 : 1'b0};
            er = {(k == 3) ? 1'b1 : 1'b0, (k == 5) ? 1'b1 : 1'b0};
            push(0, ed, er, 2'b00, "bounce");
        end

        // DC=1: output follows with one-edge latency, pulses back to back.
        for (int k = 0; k < 5; k++) begin
            tick(); ifc1.din = pat_1[k];
            push(1, {1'b0, pat_1[k]}, (k == 0 || k == 2) ? 2'b01 : 2'b00,
                 (k == 1 || k == 3) ? 2'b01 : 2'b00, "dc1_follow");
        end

        // DC=8: reset 5 cycles into a high, then a fresh rise 8 edges after release.
        for (int k = 0; k < 5; k++) begin
            tick(); ifc8.din = 1'b1;
            push(2, 2'b00, 2'b00, 2'b00, "dc8_pending");
        end
        for (int k = 0; k < 2; k++) begin
            tick(); rst8 = 1'b0;
            push(2, 2'b00, 2'b00, 2'b00, "dc8_rst_mid_pend");
        end
        for (int k = 0; k < 10; k++) begin
            tick(); rst8 = 1'b1; ifc8.din = 1'b1;
            push(2, (k >= 7) ? 2'b01 : 2'b00, (k == 7) ? 2'b01 : 2'b00, 2'b00, "dc8_after_rst");
        end

        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_debounce.md
# sync_debounce

Per-bit debouncer and edge detector sitting directly downstream of the multi-stage synchronizer. It takes the already-synchronized `dout` bus of that synchronizer (same clock domain) and filters glitches by requiring `DEBOUNCE_CYC` consecutive equal samples. It then presents a clean level plus single-cycle rise/fall pulses to control logic (button, strap and status inputs).

## Interface
- `WIDTH`, 1: number of independent channels; must match the upstream synchronizer width.
- `DEBOUNCE_CYC`, 16: consecutive equal samples required to accept a new level; legal range 1 to 65535.
- `CNT_W`, `$clog2(DEBOUNCE_CYC+1)`: derived counter width (localparam, not overridable).

- `clk`  input  1  single clock; all logic on rising edge.
- `rst_n`  input  1  asynchronous assert, active-low reset (one clock; reset is asynchronous and active-low).
- `din`  input  WIDTH  synchronized input bus from the synchronizer stage; never raw async.
- `dout`  output  WIDTH  debounced level, registered.
- `rise`  output  WIDTH  one-cycle pulse, bit i high the cycle `dout[i]` first reads 1.
- `fall`  output  WIDTH  one-cycle pulse, bit i high the cycle `dout[i]` first reads 0.

## Operation
- Channels fully independent; no cross-channel interaction.
- Per-channel 4-state FSM: `ST_LO`, `PEND_HI`, `ST_HI`, `PEND_LO`; plus counter `cnt` of width `CNT_W`.
- `ST_LO`, with `din`=0: hold, `cnt`=0.
- `ST_LO`, with `din`=1: go to `PEND_HI`, `cnt`=1. If `DEBOUNCE_CYC`==1, go directly to `ST_HI` instead, with `dout`=1 and `rise`=1.
- `PEND_HI`, with `din`=1:
  - If `cnt`==`DEBOUNCE_CYC`-1: go to `ST_HI`, `dout`←1, `rise`←1, `cnt`←0.
  - Else `cnt`←`cnt`+1.
- `PEND_HI`, with `din`=0: return to `ST_LO`, `cnt`←0. No pulse, `dout` unchanged.
- `ST_HI` and `PEND_LO`: mirror image of the above, with `fall` replacing `rise` and `dout`←0.
- `cnt` never exceeds `DEBOUNCE_CYC`-1; no wrap-around possible.
- `rise` and `fall` are each high for exactly one cycle per accepted transition and are never simultaneously high on the same bit.
- `dout` toggles only on accepted transitions. A glitch shorter than `DEBOUNCE_CYC` samples produces no output activity.

## Timing
- Reset values: all FSMs in `ST_LO`; `cnt`=0; `dout`=0, `rise`=0, `fall`=0. This matches the synchronizer reset value of 0, so no spurious edge occurs after reset.
- Latency: if `din[i]` is first sampled at its new value on edge E0 and stays stable, `dout[i]` and the pulse update on edge E0+`DEBOUNCE_CYC`-1. For `DEBOUNCE_CYC`=1 this is the same edge as first sample.
- Total latency from the raw pin is the synchronizer stage count plus `DEBOUNCE_CYC` cycles.
- All outputs are registered; no combinational path from `din` to any output.
- Reset mid-pending: `rst_n` low forces reset values asynchronously. After release, the channel restarts from `ST_LO`. A `din` held at 1 through reset produces a fresh `rise` `DEBOUNCE_CYC` cycles after release.
- Reset mid-pulse: the pulse is cut immediately and is not re-issued.
- A `din` change on the same edge as pending completion is evaluated on the old state. In `PEND_HI`, a 1 completes and a 0 aborts.

## Structure
- Shared package `sync_pkg`: state encoding localparams `ST_LO`=2'b00, `PEND_HI`=2'b01, `ST_HI`=2'b11, `PEND_LO`=2'b10. Bit 1 equals the current `dout`.
- Sub-module `debounce_ch`: one channel (FSM, counter, three output flops), parameterized by `DEBOUNCE_CYC`.
- Top module instantiates `debounce_ch` `WIDTH` times in a generate loop.
- Estimated RTL: about 150 lines total.

## Test plan
- Reset check, `DEBOUNCE_CYC`=4: hold `rst_n`=0 with `din`=1 → `dout`=0, `rise`=0, `fall`=0. Release → `rise` pulses once on the 4th edge after release and `dout`=1 thereafter.
- Clean edge, `DEBOUNCE_CYC`=4: `din` 0→1 held for 10 cycles → `dout` high on edge E0+3, `rise` high for exactly 1 cycle, `fall` never asserts.
- Glitch reject, `DEBOUNCE_CYC`=4: `din` high for 3 cycles then low → `dout` stays 0, no pulses. A later 4-cycle high is accepted.
- Bounce, `DEBOUNCE_CYC`=4, `WIDTH`=2: bit0 toggles 1,0,1,1,1,1 while bit1 is constant 1 from reset → bit0 `rise` once, 3 edges after its final 0→1 sample. Bit1 `rise` once, 4 cycles after reset release, unaffected by bit0.
- Minimum filter, `DEBOUNCE_CYC`=1: `din` pattern 1,0,1 → `dout` follows with 1-edge latency, and `rise`,`fall`,`rise` appear on consecutive cycles.
- Reset mid-pending, `DEBOUNCE_CYC`=8: assert `rst_n` 5 cycles into a high → no pulse. After release with `din`=1, `rise` pulses 8 edges later.
